// File: rtl/hn_router_rsp_map.sv
// HN-side transaction map: remembers the requesting RN per tid, forwards requests to the home node
// and steers each HN response back to the RN that issued it.
module hn_router_rsp_map #(
  parameter int          TXN_NUM        = 16,
  parameter int          TXN_ID_W       = $clog2(TXN_NUM),
  parameter int          NodeID_X_Width = 4,
  parameter int          NodeID_Y_Width = 4,
  parameter int          FLIT_W         = 256,
  parameter logic [1:0]  HN_DEVICE_PORT = 2'd1,
  parameter bit          USE_QOS_VALUE  = 1'b1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NodeID_X_Width-1:0]         node_id_x_i,
  input  logic [NodeID_Y_Width-1:0]         node_id_y_i,
  input  logic                              req_flit_v_i,
  input  logic [FLIT_W-1:0]                 req_flit_i,
  output logic                              req_flit_rdy_o,
  output logic                              hn_req_v_o,
  output logic [FLIT_W-1:0]                 hn_req_o,
  input  logic                              hn_req_rdy_i,
  input  logic                              hn_rsp_v_i,
  input  logic [FLIT_W-1:0]                 hn_rsp_i,
  output logic                              hn_rsp_rdy_o,
  input  logic [2:0]                        rsp_look_ahead_routing_i,
  output logic                              rsp_flit_v_o,
  output logic [FLIT_W-1:0]                 rsp_flit_o,
  output logic [2*(NodeID_X_Width+NodeID_Y_Width+4)+3+4-1:0] rsp_flit_dec_o,
  input  logic                              rsp_flit_rdy_i,
  output logic [TXN_NUM-1:0]                txn_busy_o,
  output logic                              err_misroute_o,
  output logic                              err_unknown_tid_o
);

  // Flit layout (LSB first): tgt_id, src_id, tid[7:0], qos[3:0], payload.
  // Node id packing (MSB first): x, y, device_port[1:0], device_id[1:0].
  localparam int ID_W    = NodeID_X_Width + NodeID_Y_Width + 4;
  localparam int TGT_LSB = 0;
  localparam int SRC_LSB = ID_W;
  localparam int TID_LSB = 2 * ID_W;
  localparam int QOS_LSB = TID_LSB + 8;
  localparam int QOS_W   = 4;
  localparam int Y_LSB   = 4;
  localparam int X_LSB   = 4 + NodeID_Y_Width;

  logic [TXN_NUM-1:0]  valid_reg;
  logic [ID_W-1:0]     src_mem [TXN_NUM];

  logic [TXN_ID_W-1:0] req_tid;
  logic [TXN_ID_W-1:0] rsp_tid;
  logic                req_fire;
  logic                rsp_fire;
  logic                rsp_hit;
  logic                rsp_miss;
  logic                misroute;
  logic [ID_W-1:0]     hn_src_id;
  logic [ID_W-1:0]     rec_src_id;
  logic [QOS_W-1:0]    qos_next;
  logic [FLIT_W-1:0]   rsp_flit_next;

  assign req_tid = req_flit_i[TID_LSB +: TXN_ID_W];
  assign rsp_tid = hn_rsp_i[TID_LSB +: TXN_ID_W];

  // An occupied tid stalls the request rather than overwriting the recorded source.
  assign req_flit_rdy_o = (!hn_req_v_o || hn_req_rdy_i) && !valid_reg[req_tid];
  assign req_fire       = req_flit_v_i && req_flit_rdy_o;

  assign hn_rsp_rdy_o = !rsp_flit_v_o || rsp_flit_rdy_i;
  assign rsp_fire     = hn_rsp_v_i && hn_rsp_rdy_o;
  assign rsp_hit      = rsp_fire && valid_reg[rsp_tid];
  assign rsp_miss     = rsp_fire && !valid_reg[rsp_tid];

  assign misroute =
      (req_flit_i[TGT_LSB + X_LSB +: NodeID_X_Width] != node_id_x_i) ||
      (req_flit_i[TGT_LSB + Y_LSB +: NodeID_Y_Width] != node_id_y_i);

  assign hn_src_id  = {node_id_x_i, node_id_y_i, HN_DEVICE_PORT, 2'b00};
  assign rec_src_id = src_mem[rsp_tid];
  assign qos_next   = USE_QOS_VALUE ? hn_rsp_i[QOS_LSB +: QOS_W] : '0;

  always_comb begin
    rsp_flit_next                     = hn_rsp_i;
    rsp_flit_next[TGT_LSB +: ID_W]    = rec_src_id;
    rsp_flit_next[SRC_LSB +: ID_W]    = hn_src_id;
  end

  // Alloc reads the pre-free valid bit, so a same-tid alloc waits one cycle.
  generate
    for (genvar gi = 0; gi < TXN_NUM; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          valid_reg[gi] <= 1'b0;
        end else if (req_fire && (req_tid == TXN_ID_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end else if (rsp_hit && (rsp_tid == TXN_ID_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (req_fire) begin
      src_mem[req_tid] <= req_flit_i[SRC_LSB +: ID_W];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hn_req_v_o <= 1'b0;
      hn_req_o   <= '0;
    end else if (req_fire) begin
      hn_req_v_o <= 1'b1;
      hn_req_o   <= req_flit_i;
    end else if (hn_req_rdy_i) begin
      hn_req_v_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_flit_v_o   <= 1'b0;
      rsp_flit_o     <= '0;
      rsp_flit_dec_o <= '0;
    end else if (rsp_hit) begin
      rsp_flit_v_o   <= 1'b1;
      rsp_flit_o     <= rsp_flit_next;
      rsp_flit_dec_o <= {rec_src_id, hn_src_id, rsp_look_ahead_routing_i, qos_next};
    end else if (rsp_flit_rdy_i) begin
      rsp_flit_v_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_misroute_o    <= 1'b0;
      err_unknown_tid_o <= 1'b0;
    end else begin
      if (req_fire && misroute) err_misroute_o <= 1'b1;
      if (rsp_miss)             err_unknown_tid_o <= 1'b1;
    end
  end

  assign txn_busy_o = valid_reg;

endmodule

// File: tb/tb_hn_router_rsp_map.sv
// Scoreboard bench for hn_router_rsp_map: expected HN requests and router responses are queued
// when accepted at the inputs and compared when the DUT presents them.
module tb_hn_router_rsp_map;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   node_id_x_i;
  logic [3:0]   node_id_y_i;
  logic         req_flit_v_i;
  logic [255:0] req_flit_i;
  logic         req_flit_rdy_o;
  logic         hn_req_v_o;
  logic [255:0] hn_req_o;
  logic         hn_req_rdy_i;
  logic         hn_rsp_v_i;
  logic [255:0] hn_rsp_i;
  logic         hn_rsp_rdy_o;
  logic [2:0]   rsp_look_ahead_routing_i;
  logic         rsp_flit_v_o;
  logic [255:0] rsp_flit_o;
  logic [30:0]  rsp_flit_dec_o;
  logic         rsp_flit_rdy_i;
  logic [15:0]  txn_busy_o;
  logic         err_misroute_o;
  logic         err_unknown_tid_o;

  hn_router_rsp_map dut (
    .clk(clk), .rstn(rstn),
    .node_id_x_i(node_id_x_i), .node_id_y_i(node_id_y_i),
    .req_flit_v_i(req_flit_v_i), .req_flit_i(req_flit_i), .req_flit_rdy_o(req_flit_rdy_o),
    .hn_req_v_o(hn_req_v_o), .hn_req_o(hn_req_o), .hn_req_rdy_i(hn_req_rdy_i),
    .hn_rsp_v_i(hn_rsp_v_i), .hn_rsp_i(hn_rsp_i), .hn_rsp_rdy_o(hn_rsp_rdy_o),
    .rsp_look_ahead_routing_i(rsp_look_ahead_routing_i),
    .rsp_flit_v_o(rsp_flit_v_o), .rsp_flit_o(rsp_flit_o), .rsp_flit_dec_o(rsp_flit_dec_o),
    .rsp_flit_rdy_i(rsp_flit_rdy_i),
    .txn_busy_o(txn_busy_o), .err_misroute_o(err_misroute_o), .err_unknown_tid_o(err_unknown_tid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_req_q[$];
  logic [255:0] exp_rsp_q[$];
  logic [30:0]  exp_dec_q[$];
  logic [15:0]  mdl_busy;
  logic [11:0]  mdl_src [16];
  logic         bp_en = 1'b0;
  logic [255:0] mon_e;
  logic [30:0]  mon_d;
  logic [255:0] held_flit;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] nid(input logic [3:0] x, input logic [3:0] y,
                                      input logic [1:0] p, input logic [1:0] d);
    return {x, y, p, d};
  endfunction

  function automatic logic [255:0] mk(input logic [11:0] tgt, input logic [11:0] src,
                                      input logic [7:0] tid, input logic [3:0] qos,
                                      input logic [219:0] data);
    return {data, qos, tid, src, tgt};
  endfunction

  always @(posedge clk) begin
    #1;
    hn_req_rdy_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: every transfer presented by the DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (hn_req_v_o && hn_req_rdy_i) begin
        if (exp_req_q.size() == 0) chk("hn_req_unexpected", 1, 0);
        else begin
          mon_e = exp_req_q.pop_front();
          chk("hn_req", hn_req_o, mon_e);
        end
      end
      if (rsp_flit_v_o && rsp_flit_rdy_i) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mon_e = exp_rsp_q.pop_front();
          mon_d = exp_dec_q.pop_front();
          chk("rsp_flit", rsp_flit_o, mon_e);
          chk("rsp_dec", rsp_flit_dec_o, mon_d);
        end
      end
    end
  end

  task automatic drive_req(input logic [255:0] f);
    int n = 0;
    req_flit_v_i = 1'b1;
    req_flit_i   = f;
    @(negedge clk);
    while (!req_flit_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_flit_rdy_o) chk("req_accept_timeout", 0, 1);
    else begin
      exp_req_q.push_back(f);
      mdl_busy[f[27:24]] = 1'b1;
      mdl_src[f[27:24]]  = f[23:12];
    end
    @(posedge clk);
    #1 req_flit_v_i = 1'b0;
  endtask

  task automatic accept_rsp_model(input logic [255:0] f);
    logic [255:0] e;
    if (mdl_busy[f[27:24]]) begin
      e = f;
      e[11:0]  = mdl_src[f[27:24]];
      e[23:12] = nid(4'd1, 4'd0, 2'd1, 2'd0);
      exp_rsp_q.push_back(e);
      exp_dec_q.push_back({e[11:0], e[23:12], rsp_look_ahead_routing_i, f[35:32]});
      mdl_busy[f[27:24]] = 1'b0;
    end
  endtask

  task automatic drive_rsp(input logic [255:0] f);
    int n = 0;
    hn_rsp_v_i = 1'b1;
    hn_rsp_i   = f;
    @(negedge clk);
    while (!hn_rsp_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!hn_rsp_rdy_o) chk("rsp_accept_timeout", 0, 1);
    else accept_rsp_model(f);
    @(posedge clk);
    #1 hn_rsp_v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    node_id_x_i = 4'd1;
    node_id_y_i = 4'd0;
    req_flit_v_i = 1'b0;
    req_flit_i = '0;
    hn_rsp_v_i = 1'b0;
    hn_rsp_i = '0;
    rsp_look_ahead_routing_i = 3'd2;
    rsp_flit_rdy_i = 1'b1;
    mdl_busy = '0;
    repeat (3) @(negedge clk);
    chk("rst_hn_req_v", hn_req_v_o, 0);
    chk("rst_rsp_v", rsp_flit_v_o, 0);
    chk("rst_busy", txn_busy_o, 0);
    chk("rst_errs", {err_misroute_o, err_unknown_tid_o}, 0);
    chk("rst_payloads", hn_req_o | rsp_flit_o | 256'(rsp_flit_dec_o), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic round trip on tid 3.
    drive_req(mk(nid(1, 0, 0, 0), nid(2, 1, 0, 0), 8'd3, 4'h5, 220'hABCDEF));
    @(negedge clk);
    chk("t3_busy", txn_busy_o[3], 1);
    @(posedge clk); #1;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(9, 9, 0, 0), 8'd3, 4'h6, 220'h123456));
    @(negedge clk);
    chk("t3_rsp_v", rsp_flit_v_o, 1);
    chk("t3_rsp_tgt", rsp_flit_o[11:0], nid(2, 1, 0, 0));
    chk("t3_rsp_src", rsp_flit_o[23:12], nid(1, 0, 1, 0));
    chk("t3_freed", txn_busy_o[3], 0);
    chk("no_misroute", err_misroute_o, 0);
    @(posedge clk); #1;

    // tid 5 occupancy stall, then same-cycle free and realloc.
    drive_req(mk(nid(1, 0, 0, 0), nid(3, 2, 2, 1), 8'd5, 4'h1, 220'h55));
    req_flit_v_i = 1'b1;
    req_flit_i   = mk(nid(1, 0, 0, 0), nid(4, 4, 1, 1), 8'd5, 4'h2, 220'h5555);
    repeat (2) begin
      @(negedge clk);
      chk("t5_stall", req_flit_rdy_o, 0);
      @(posedge clk); #1;
    end
    hn_rsp_v_i = 1'b1;
    hn_rsp_i   = mk(nid(1, 0, 0, 0), nid(7, 7, 0, 0), 8'd5, 4'h3, 220'hBEEF);
    @(negedge clk);
    chk("t5_same_cycle_stall", req_flit_rdy_o, 0);
    chk("t5_rsp_rdy", hn_rsp_rdy_o, 1);
    accept_rsp_model(hn_rsp_i);
    @(posedge clk); #1;
    hn_rsp_v_i = 1'b0;
    @(negedge clk);
    chk("t5_realloc_rdy", req_flit_rdy_o, 1);
    exp_req_q.push_back(req_flit_i);
    mdl_busy[5] = 1'b1;
    mdl_src[5]  = req_flit_i[23:12];
    @(posedge clk); #1;
    req_flit_v_i = 1'b0;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(7, 7, 0, 0), 8'd5, 4'h4, 220'hCAFE));

    // Unknown tid.
    drive_rsp(mk(nid(1, 0, 0, 0), nid(7, 7, 0, 0), 8'd7, 4'h0, 220'hDEAD));
    repeat (2) @(negedge clk);
    chk("unk_err", err_unknown_tid_o, 1);
    chk("unk_no_rsp", rsp_flit_v_o, 0);
    @(posedge clk); #1;

    // Misrouted request is still forwarded unchanged.
    drive_req(mk(nid(0, 1, 0, 0), nid(2, 2, 0, 0), 8'd1, 4'h9, 220'h0F0F));
    @(negedge clk);
    chk("misroute_err", err_misroute_o, 1);
    @(posedge clk); #1;
    rsp_look_ahead_routing_i = 3'd4;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd1, 4'hA, 220'h1111));

    // Back-pressure hold with three queued responses.
    drive_req(mk(nid(1, 0, 0, 0), nid(5, 3, 1, 0), 8'd8, 4'h1, 220'h8));
    drive_req(mk(nid(1, 0, 0, 0), nid(6, 3, 1, 1), 8'd9, 4'h2, 220'h9));
    drive_req(mk(nid(1, 0, 0, 0), nid(7, 3, 0, 1), 8'd10, 4'h3, 220'hA));
    rsp_flit_rdy_i = 1'b0;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd8, 4'h7, 220'h88));
    hn_rsp_v_i = 1'b1;
    hn_rsp_i   = mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd9, 4'h8, 220'h99);
    @(negedge clk);
    held_flit = rsp_flit_o;
    repeat (4) begin
      chk("hold_rdy", hn_rsp_rdy_o, 0);
      chk("hold_v", rsp_flit_v_o, 1);
      chk("hold_data", rsp_flit_o, held_flit);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_flit_rdy_i = 1'b1;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd9, 4'h8, 220'h99));
    drive_rsp(mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd10, 4'h9, 220'hAA));
    repeat (3) @(negedge clk);
    chk("unk_sticky", err_unknown_tid_o, 1);
    chk("drained_busy", txn_busy_o, 0);
    @(posedge clk); #1;

    // Fill the table under random HN back-pressure, then reset mid-stream.
    bp_en = 1'b1;
    for (int t = 0; t < 16; t++)
      drive_req(mk(nid(1, 0, 0, 0), nid(4'(t), 4'(15 - t), 2'(t), 2'(t >> 2)), 8'(t), 4'(t), 220'(t * 77)));
    bp_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_busy", txn_busy_o, 16'hFFFF);
    @(posedge clk); #1;
    rsp_flit_rdy_i = 1'b0;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd4, 4'h2, 220'h44));
    req_flit_v_i = 1'b1;
    req_flit_i   = mk(nid(1, 0, 0, 0), nid(3, 3, 0, 0), 8'd2, 4'h0, 220'h2);
    rstn = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
    exp_dec_q.delete();
    mdl_busy = '0;
    #2;
    chk("mid_rst_rsp_v", rsp_flit_v_o, 0);
    chk("mid_rst_hn_req_v", hn_req_v_o, 0);
    chk("mid_rst_busy", txn_busy_o, 0);
    chk("mid_rst_errs", {err_misroute_o, err_unknown_tid_o}, 0);
    chk("mid_rst_payloads", hn_req_o | rsp_flit_o | 256'(rsp_flit_dec_o), 0);
    req_flit_v_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    rsp_flit_rdy_i = 1'b1;
    @(posedge clk); #1;
    drive_req(mk(nid(1, 0, 0, 0), nid(8, 1, 3, 2), 8'd0, 4'hC, 220'hF00D));
    @(negedge clk);
    chk("fresh_busy", txn_busy_o, 16'h0001);
    @(posedge clk); #1;
    drive_rsp(mk(nid(1, 0, 0, 0), nid(0, 0, 0, 0), 8'd0, 4'hD, 220'hD00F));
    repeat (4) @(negedge clk);
    chk("sb_req_empty", exp_req_q.size(), 0);
    chk("sb_rsp_empty", exp_rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
